// File: rtl/clock_display.sv
// Six-digit multiplexed 7-segment driver for a time/date clock.
// Shows HH MM SS or YY MM DD; a debounced pushbutton toggles the page at frame boundaries.
module clock_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] year,
    input  logic [7:0] month,
    input  logic [7:0] day,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic       page_btn,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       page
);
    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = $clog2(DB_CYCLES + 1);

    typedef enum logic {DB_STABLE, DB_CHECK} db_state_t;

    logic [PW-1:0]  pre_cnt;
    logic [2:0]     idx;
    logic           scan_tick, frame_edge;
    logic [7:0]     sh_year, sh_month, sh_day, sh_hour, sh_minute, sh_second;
    logic           pending;
    logic           sync_p0, sync_p1;
    db_state_t      db_state, db_state_n;
    logic [DBW-1:0] db_cnt, db_cnt_n;
    logic           lvl, lvl_n, press;
    logic [7:0]     fld;
    logic [6:0]     seg_nxt;

    function automatic logic [6:0] digit_seg(input logic [7:0] d);
        case (d)
            8'd0:    digit_seg = 7'h3F;
            8'd1:    digit_seg = 7'h06;
            8'd2:    digit_seg = 7'h5B;
            8'd3:    digit_seg = 7'h4F;
            8'd4:    digit_seg = 7'h66;
            8'd5:    digit_seg = 7'h6D;
            8'd6:    digit_seg = 7'h7D;
            8'd7:    digit_seg = 7'h07;
            8'd8:    digit_seg = 7'h7F;
            8'd9:    digit_seg = 7'h6F;
            default: digit_seg = 7'h00;
        endcase
    endfunction

    // Out-of-range fields render as a dash on both digits
    function automatic logic [6:0] field_seg(input logic [7:0] v, input logic ones);
        if (v > 8'd99)
            field_seg = 7'h40;
        else if (ones)
            field_seg = digit_seg(v % 8'd10);
        else
            field_seg = digit_seg(v / 8'd10);
    endfunction

    assign scan_tick  = (pre_cnt == PW'(SCAN_DIV - 1));
    assign frame_edge = scan_tick && (idx == 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (scan_tick) begin
            pre_cnt <= '0;
            idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Frame-boundary snapshot keeps a digit pair from tearing mid-scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_year   <= '0;
            sh_month  <= '0;
            sh_day    <= '0;
            sh_hour   <= '0;
            sh_minute <= '0;
            sh_second <= '0;
            page      <= 1'b0;
        end else if (frame_edge) begin
            sh_year   <= year;
            sh_month  <= month;
            sh_day    <= day;
            sh_hour   <= hour;
            sh_minute <= minute;
            sh_second <= second;
            page      <= pending;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            db_state <= DB_STABLE;
            db_cnt   <= '0;
            lvl      <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sync_p0  <= page_btn;
            sync_p1  <= sync_p0;
            db_state <= db_state_n;
            db_cnt   <= db_cnt_n;
            lvl      <= lvl_n;
            if (press)
                pending <= ~pending;
        end
    end

    always_comb begin
        db_state_n = db_state;
        db_cnt_n   = db_cnt;
        lvl_n      = lvl;
        press      = 1'b0;
        case (db_state)
            DB_STABLE: begin
                if (sync_p1 != lvl) begin
                    db_state_n = DB_CHECK;
                    db_cnt_n   = DBW'(1);
                end
            end
            DB_CHECK: begin
                if (sync_p1 == lvl) begin
                    db_state_n = DB_STABLE;
                end else begin
                    db_cnt_n = db_cnt + DBW'(1);
                    if (db_cnt + DBW'(1) == DBW'(DB_CYCLES)) begin
                        lvl_n      = sync_p1;
                        db_state_n = DB_STABLE;
                        press      = sync_p1;
                    end
                end
            end
            default: db_state_n = DB_STABLE;
        endcase
    end

    always_comb begin
        fld = 8'd0;
        case (idx)
            3'd0, 3'd1: fld = page ? sh_year  : sh_hour;
            3'd2, 3'd3: fld = page ? sh_month : sh_minute;
            3'd4, 3'd5: fld = page ? sh_day   : sh_second;
            default:    fld = 8'd0;
        endcase
        seg_nxt = field_seg(fld, idx[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '0;
            dp  <= 1'b0;
            an  <= '0;
        end else if (blank) begin
            seg <= '0;
            dp  <= 1'b0;
            an  <= '0;
        end else begin
            seg <= seg_nxt;
            dp  <= (idx == 3'd1) || (idx == 3'd3);
            an  <= 6'(1) << idx;
        end
    end

endmodule

// File: tb/tb_clock_display.sv
// Randomized bench for clock_display against a cycle-count based reference model.
module tb_clock_display;
    localparam int S  = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] year = 0, month = 0, day = 0, hour = 0, minute = 0, second = 0;
    logic       page_btn = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       page;

    int n_cmp = 0;
    int n_bad = 0;

    clock_display #(.SCAN_DIV(S), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .year(year), .month(month), .day(day),
        .hour(hour), .minute(minute), .second(second),
        .page_btn(page_btn), .blank(blank),
        .seg(seg), .dp(dp), .an(an), .page(page)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int         m_edges;
    int         m_time [3];
    int         m_date [3];
    logic       m_page, m_pending, m_lvl, m_b1, m_b2;
    int         m_run;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_an;
    logic       e_page;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_edges = 0;
        for (int i = 0; i < 3; i++) begin
            m_time[i] = 0;
            m_date[i] = 0;
        end
        m_page = 0; m_pending = 0; m_lvl = 0; m_b1 = 0; m_b2 = 0; m_run = 0;
        e_seg = 0; e_dp = 0; e_an = 0; e_page = 0;
    endtask

    // Evaluated at each rising edge with the inputs that edge samples
    task automatic model_edge();
        int   i, v, d;
        logic samp;
        if (rst) begin
            model_reset();
            return;
        end
        m_edges++;
        i = ((m_edges - 1) / S) % 6;
        if (blank) begin
            e_seg = 0; e_dp = 0; e_an = 0;
        end else begin
            v = m_page ? m_date[i / 2] : m_time[i / 2];
            d = (i % 2) ? v % 10 : v / 10;
            e_seg = (v > 99) ? 7'h40 : seg_tab[d];
            e_dp  = (i == 1) || (i == 3);
            e_an  = 6'(1 << i);
        end
        if (m_edges % (6 * S) == 0) begin
            m_time[0] = hour;  m_time[1] = minute; m_time[2] = second;
            m_date[0] = year;  m_date[1] = month;  m_date[2] = day;
            m_page    = m_pending;
        end
        samp = m_b2;
        m_b2 = m_b1;
        m_b1 = page_btn;
        if (samp != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl = samp;
                m_run = 0;
                if (samp) m_pending = ~m_pending;
            end
        end else begin
            m_run = 0;
        end
        e_page = m_page;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("seg",  32'(seg),  32'(e_seg));
        check("dp",   32'(dp),   32'(e_dp));
        check("an",   32'(an),   32'(e_an));
        check("page", 32'(page), 32'(e_page));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic set_fields(input int h, input int mi, input int s,
                              input int y, input int mo, input int dd);
        hour = 8'(h); minute = 8'(mi); second = 8'(s);
        year = 8'(y); month = 8'(mo); day = 8'(dd);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        run(3);
        #1;
        check("rst_seg", 32'(seg), 0);
        check("rst_an",  32'(an),  0);
        check("rst_page", 32'(page), 0);
        @(negedge clk);
        rst = 1'b0;

        // Time 12:34:56 for two full frames
        set_fields(12, 34, 56, 24, 7, 15);
        run(2 * 6 * S + 4);

        // Long press mid-frame, then release
        page_btn = 1'b1;
        run(20);
        page_btn = 1'b0;
        run(6 * S * 2);

        // Bounce that never settles long enough
        page_btn = 1'b1; run(5);
        page_btn = 1'b0; run(3);
        page_btn = 1'b1; run(5);
        page_btn = 1'b0; run(6 * S * 2);

        // Press again to return to time page, then out-of-range hour
        page_btn = 1'b1; run(12);
        page_btn = 1'b0; run(6 * S * 2);
        set_fields(150, 7, 0, 99, 12, 31);
        run(6 * S * 2);

        // Blank window
        blank = 1'b1; run(10);
        blank = 1'b0; run(6 * S + 4);

        // Randomized traffic
        for (int blk = 0; blk < 60; blk++) begin
            if ($urandom_range(0, 2) == 0)
                set_fields($urandom_range(0, 255), $urandom_range(0, 99), $urandom_range(0, 120),
                           $urandom_range(0, 110), $urandom_range(0, 255), $urandom_range(0, 99));
            page_btn = 1'($urandom_range(0, 1));
            blank    = ($urandom_range(0, 7) == 0);
            run($urandom_range(1, 20));
        end
        blank = 1'b0;
        page_btn = 1'b0;
        run(30);

        // Make sure the date page is showing, then reset mid-frame
        if (!m_page) begin
            page_btn = 1'b1; run(12);
            page_btn = 1'b0; run(6 * S * 2);
        end
        run(S + 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_seg",  32'(seg),  0);
        check("async_dp",   32'(dp),   0);
        check("async_an",   32'(an),   0);
        check("async_page", 32'(page), 0);
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(1);
        check("post_rst_seg", 32'(seg), 32'h3F);
        check("post_rst_an",  32'(an),  32'h01);
        run(6 * S * 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_display.md
CLOCK_DISPLAY -- requirements
Module: clock_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000: consecutive stable cycles required to accept a button level (legal range >= 2).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports year, month, day, hour, minute, second  input  8 each  binary time fields from the clock counter.
REQ-006 SHALL have port page_btn  input  1  raw, asynchronous page-toggle pushbutton, active-high.
REQ-007 SHALL have port blank  input  1  synchronous display blank request.
REQ-008 SHALL have port seg  output  7  segment drive, active-high; bit0=a ... bit6=g.
REQ-009 SHALL have port dp  output  1  decimal-point drive, active-high.
REQ-010 SHALL have port an  output  6  digit enable, one-hot active-high; bit0 = leftmost digit.
REQ-011 SHALL have port page  output  1  page being displayed: 0 = time (HH MM SS), 1 = date (YY MM DD).

Function
REQ-012 SHALL count a prescaler 0..SCAN_DIV-1; on terminal count it SHALL wrap to 0 and advance the digit index 0..5, with 5 wrapping to 0.
REQ-013 SHALL define a frame boundary as the index advancing from 5 to 0.
REQ-014 SHALL capture all six inputs and the pending page bit into shadow registers on each frame boundary; digits SHALL be decoded only from the shadow registers.
REQ-015 SHALL map index to fields as follows: page 0, indices 0/1 = hour tens/ones, 2/3 = minute, 4/5 = second; page 1, indices 0/1 = year, 2/3 = month, 4/5 = day.
REQ-016 SHALL derive tens = v/10 and ones = v%10 for a field value v of 0..99.
REQ-017 SHALL drive seg = 7'b1000000 (dash, g only) on both digits of a field whose value is greater than 99.
REQ-018 SHALL use standard hex-free 0-9 patterns, e.g. 0 = 7'h3F, 1 = 7'h06, 8 = 7'h7F.
REQ-019 SHALL drive dp = 1 on indices 1 and 3 and dp = 0 on all other indices, on both pages.
REQ-020 SHALL register seg, dp and an, so they reflect the current index one cycle after the index changes.
REQ-021 SHALL force an = 0, seg = 0 and dp = 0 on the cycle after blank is sampled 1; the scan counters and shadow capture SHALL continue while blanked.
REQ-022 SHALL pass page_btn through a 2-flop synchronizer before any other use.
REQ-023 SHALL run a debouncer with two states: STABLE (accepted level L) and CHECK (counting); the synchronized level differing from L SHALL move it to CHECK with a counter at 1.
REQ-024 In CHECK, the debouncer SHALL increment the counter while the level differs from L; on reaching DB_CYCLES it SHALL set L to the new level and return to STABLE; a level equal to L SHALL return it to STABLE with no change.
REQ-025 SHALL toggle the pending page bit on each accepted 0->1 transition of L; a 1->0 transition SHALL have no effect.
REQ-026 SHALL update the page output only at a frame boundary, from the pending bit.
REQ-027 SHALL count two accepted presses within one frame as a net zero change.

Reset
REQ-028 While rst = 1, SHALL hold seg = 0, dp = 0, an = 0 and page = 0.
REQ-029 While rst = 1, SHALL hold the prescaler, index, shadows, pending page bit, debounce counter, L, and synchronizer flops at 0, with the debouncer in STABLE.
REQ-030 On rst deassertion, SHALL show index 0 one cycle later, decoded from the zero shadows ("0"), until the first frame boundary.
REQ-031 SHALL return every output to its reset value immediately on rst assertion mid-frame, independent of clk.

Verification (SCAN_DIV=4, DB_CYCLES=8)
REQ-032 Time 12:34:56, page 0, run 2 frames -> the second frame shows an 000001..100000 with seg 06,5B,4F,66,6D,7D and dp=1 at indices 1 and 3.
REQ-033 Hold page_btn=1 for 20 cycles mid-frame -> page stays 0 until the next frame boundary, then shows 1 with YY MM DD.
REQ-034 Apply a bounce pattern of 1 for 5 cycles, 0 for 3, 1 for 5, then release -> no page change.
REQ-035 Set hour=8'd150, minute=7 -> indices 0/1 show seg 40,40 and indices 2/3 show 3F,07.
REQ-036 Assert blank=1 for 10 cycles -> an=0 and seg=0 from the next cycle; scanning resumes at the correct index when blank is released.
REQ-037 Assert rst mid-frame with page=1 -> an=0, seg=0 and page=0 immediately; after release, index 0 shows 3F.
